wave_capture: RTL and testbench

//   Writer side of the double-buffered sample RAM that wave_display reads.

---
 rtl/wave_pkg.sv | 18 +
 rtl/wave_trigger_detect.sv | 71 +++++++
 rtl/wave_capture.sv | 119 +++++++++++
 tb/tb_wave_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// wave_pkg
//   Definitions shared by the two sides of the double-buffered sample RAM:
//   wave_capture (writer) and wave_display (reader).
//     wave_state_e   capture FSM encoding (ARMED, ACTIVE, WAIT)
//     WAVE_SAMPLES   samples stored per buffer half
//     SAMPLE_OFFSET  XOR mask turning a signed byte into offset binary
package wave_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } wave_state_e;

    localparam int         WAVE_SAMPLES  = 256;
    localparam logic [7:0] SAMPLE_OFFSET = 8'h80;

endpackage

// File: rtl/wave_trigger_detect.sv
// wave_trigger_detect
//   Rising zero-crossing detector for the audio sample stream. Keeps the sign
//   of the previous sample and pulses 'trigger' for one cycle when a strobed
//   sample is non-negative while the previous one was negative.
//
//   Optional feature (macro WAVE_CAPTURE_HYST_EN): a sticky 'seen_low' flag,
//   set by a sample below -TRIG_HYST while armed and cleared when a capture
//   starts, must be high for a trigger. This rejects chatter around zero.
//
// Ports
//   clk               in   system clock
//   reset             in   synchronous, active-high
//   new_sample_ready  in   1-cycle strobe qualifying new_sample_in
//   new_sample_in     in   signed sample, SAMPLE_W bits
//   armed             in   capture FSM is waiting for a trigger
//   capture_start     in   capture FSM accepts the trigger this cycle
//   trigger           out  1-cycle rising zero-crossing pulse
module wave_trigger_detect
    import wave_pkg::*;
#(
    parameter int                    SAMPLE_W  = 16,
    parameter logic [SAMPLE_W-1:0]   TRIG_HYST = 16'd512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_sample_ready,
    input  logic signed [SAMPLE_W-1:0] new_sample_in,
    input  logic                       armed,
    input  logic                       capture_start,
    output logic                       trigger
);

    // Only the sign of the previous sample takes part in the crossing test.
    logic prev_sample_msb;
    logic sign_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sample_msb <= 1'b0;
        end else if (new_sample_ready) begin
            prev_sample_msb <= new_sample_in[SAMPLE_W-1];
        end
    end

    assign sign_rise = new_sample_ready & prev_sample_msb & ~new_sample_in[SAMPLE_W-1];

`ifdef WAVE_CAPTURE_HYST_EN
    localparam logic signed [SAMPLE_W-1:0] HYST_LOW = -$signed(TRIG_HYST);

    logic seen_low;

    always_ff @(posedge clk) begin
        if (reset) begin
            seen_low <= 1'b0;
        end else if (capture_start) begin
            seen_low <= 1'b0;
        end else if (armed && new_sample_ready && (new_sample_in < HYST_LOW)) begin
            seen_low <= 1'b1;
        end
    end

    assign trigger = sign_rise & seen_low;
`else
    // Without hysteresis these inputs carry no information for this block.
    logic unused_inputs;
    assign unused_inputs = ^{TRIG_HYST, new_sample_in[SAMPLE_W-2:0], armed, capture_start};

    assign trigger = sign_rise;
`endif

endmodule

// File: rtl/wave_capture.sv
// wave_capture
//   Writer side of the double-buffered sample RAM read by wave_display.
//   Arms on a rising zero crossing, writes the following 2**COUNT_W samples
//   (8-bit offset binary) into the half the display is not reading, then waits
//   for the display to go idle before flipping read_index and re-arming.
//
//   Optional feature: define WAVE_CAPTURE_HYST_EN to require the signal to
//   dip below -TRIG_HYST before a crossing counts as a trigger.
//
// Ports
//   clk                in   system clock
//   reset              in   synchronous, active-high
//   new_sample_ready   in   1-cycle strobe: new_sample_in valid this cycle
//   new_sample_in      in   signed two's-complement sample, SAMPLE_W bits
//   wave_display_idle  in   display not fetching; buffer swap is safe
//   write_address      out  {~read_index, count}, COUNT_W+1 bits
//   write_enable       out  RAM write strobe
//   write_sample       out  sample MSB byte converted to offset binary
//   read_index         out  buffer half the display reads
module wave_capture
    import wave_pkg::*;
#(
    parameter int                    SAMPLE_W  = 16,
    parameter int                    COUNT_W   = 8,
    parameter logic [SAMPLE_W-1:0]   TRIG_HYST = 16'd512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_sample_ready,
    input  logic signed [SAMPLE_W-1:0] new_sample_in,
    input  logic                       wave_display_idle,
    output logic [COUNT_W:0]           write_address,
    output logic                       write_enable,
    output logic [7:0]                 write_sample,
    output logic                       read_index
);

    // Signed MSB byte -> offset binary: flipping the sign bit maps
    // 0x80..0x7F onto 0x00..0xFF.
    function automatic logic [7:0] to_offset_binary(input logic [7:0] msb_byte);
        return msb_byte ^ SAMPLE_OFFSET;
    endfunction

    wave_state_e        state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               read_index_q, read_index_d;
    logic               trigger;
    logic               armed;
    logic               capture_start;

    assign armed         = (state_q == ARMED);
    assign capture_start = armed & trigger;

    wave_trigger_detect #(
        .SAMPLE_W  (SAMPLE_W),
        .TRIG_HYST (TRIG_HYST)
    ) u_trigger (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .armed            (armed),
        .capture_start    (capture_start),
        .trigger          (trigger)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARMED;
            count_q      <= '0;
            read_index_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            read_index_q <= read_index_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        read_index_d = read_index_q;
        unique case (state_q)
            ARMED: begin
                // The trigger sample itself is not stored.
                if (trigger) begin
                    state_d = ACTIVE;
                    count_d = '0;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    // Wraps to zero on the last write of the buffer half.
                    count_d = count_q + 1'b1;
                    if (&count_q) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    // Zero-latency write port. Reset also masks the strobe so an abandoned
    // capture cannot write during the reset cycle itself.
    assign write_enable  = (state_q == ACTIVE) & new_sample_ready & ~reset;
    assign write_address = {~read_index_q, count_q};
    assign write_sample  = to_offset_binary(new_sample_in[SAMPLE_W-1 -: 8]);
    assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture
//   Directed bench for wave_capture: reset state, trigger qualification,
//   full capture into each buffer half, WAIT behaviour and buffer swap,
//   offset-binary conversion, mid-capture reset and (with
//   WAVE_CAPTURE_HYST_EN) the hysteresis trigger.
module tb_wave_capture;

    logic               clk = 1'b0;
    logic               reset;
    logic               new_sample_ready;
    logic signed [15:0] new_sample_in;
    logic               wave_display_idle;
    logic [8:0]         write_address;
    logic               write_enable;
    logic [7:0]         write_sample;
    logic               read_index;

    int n_checks = 0;
    int n_errors = 0;

    wave_capture dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        new_sample_ready = 1'b0;
    endtask

    // Present a strobed sample and move to mid-cycle for checking.
    task automatic put(input logic [15:0] s);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        #4;
    endtask

    task automatic arm_and_trigger();
`ifdef WAVE_CAPTURE_HYST_EN
        put(16'hFC00);
        step();
`endif
        put(16'hFF00);
        check_eq("pre_trigger_we", {31'd0, write_enable}, 32'd0);
        step();
        put(16'h0100);
        check_eq("trigger_sample_we", {31'd0, write_enable}, 32'd0);
        step();
    endtask

    // Strobes first..last-1 of a capture; 16'h4C00 converts to 8'hCC.
    task automatic capture(input int first, input int last, input logic [8:0] base);
        for (int i = first; i < last; i++) begin
            put(16'h4C00);
            check_eq("cap_we", {31'd0, write_enable}, 32'd1);
            check_eq("cap_addr", {23'd0, write_address}, {23'd0, base + 9'(i)});
            check_eq("cap_sample", {24'd0, write_sample}, 32'h0000_00CC);
            step();
        end
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            put(i[0] ? 16'h0100 : 16'hFF00);
            check_eq("wait_we", {31'd0, write_enable}, 32'd0);
            step();
        end
    endtask

    task automatic idle_pulse(input logic ri_before, input logic ri_after);
        wave_display_idle = 1'b1;
        #4;
        check_eq("swap_before", {31'd0, read_index}, {31'd0, ri_before});
        @(posedge clk);
        #1;
        wave_display_idle = 1'b0;
        check_eq("swap_after", {31'd0, read_index}, {31'd0, ri_after});
    endtask

    task automatic reset_dut();
        reset            = 1'b1;
        new_sample_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;
        @(posedge clk);
        #1;
        step();

        // Reset state, including a strobe held during reset.
        put(16'h4C00);
        check_eq("rst_we", {31'd0, write_enable}, 32'd0);
        check_eq("rst_read_index", {31'd0, read_index}, 32'd0);
        check_eq("rst_addr", {23'd0, write_address}, 32'h100);
        step();
        reset = 1'b0;

        // Non-crossing patterns must not start a capture.
        put(16'h0010);
        step();
        put(16'h0020);
        check_eq("pos_pos_we", {31'd0, write_enable}, 32'd0);
        step();
        put(16'h0000);
        step();
        put(16'h0000);
        check_eq("zero_zero_we", {31'd0, write_enable}, 32'd0);
        step();
        put(16'h0030);
        check_eq("no_trig_we", {31'd0, write_enable}, 32'd0);
        step();
        idle_pulse(1'b0, 1'b0);

        // First capture into half 1, with conversion vectors up front.
        arm_and_trigger();
        put(16'h8000);
        check_eq("ws_8000", {24'd0, write_sample}, 32'h00);
        check_eq("ws_8000_addr", {23'd0, write_address}, 32'h100);
        check_eq("ws_8000_we", {31'd0, write_enable}, 32'd1);
        step();
        put(16'h0000);
        check_eq("ws_0000", {24'd0, write_sample}, 32'h80);
        check_eq("ws_0000_addr", {23'd0, write_address}, 32'h101);
        step();
        put(16'h7FFF);
        check_eq("ws_7fff", {24'd0, write_sample}, 32'hFF);
        check_eq("ws_7fff_addr", {23'd0, write_address}, 32'h102);
        step();
        capture(3, 256, 9'h100);

        // WAIT ignores samples and triggers; swap then capture into half 0.
        wait_strobes(10);
        idle_pulse(1'b0, 1'b1);
        arm_and_trigger();
        capture(0, 256, 9'h000);
        wait_strobes(2);

        // Two more swaps so read_index is 1 when reset lands mid-capture.
        idle_pulse(1'b1, 1'b0);
        arm_and_trigger();
        capture(0, 256, 9'h100);
        idle_pulse(1'b0, 1'b1);
        arm_and_trigger();
        capture(0, 100, 9'h000);

        reset = 1'b1;
        put(16'h4C00);
        check_eq("midrst_we", {31'd0, write_enable}, 32'd0);
        step();
        reset = 1'b0;
        check_eq("midrst_read_index", {31'd0, read_index}, 32'd0);
        check_eq("midrst_addr", {23'd0, write_address}, 32'h100);
        put(16'h0010);
        check_eq("midrst_we_a", {31'd0, write_enable}, 32'd0);
        step();
        put(16'h0020);
        check_eq("midrst_we_b", {31'd0, write_enable}, 32'd0);
        step();
        arm_and_trigger();
        put(16'h4C00);
        check_eq("retrig_we", {31'd0, write_enable}, 32'd1);
        check_eq("retrig_addr", {23'd0, write_address}, 32'h100);
        step();
        reset_dut();

`ifdef WAVE_CAPTURE_HYST_EN
        // A shallow dip does not qualify; a dip below -512 does.
        put(16'hFFF0);
        step();
        put(16'h0010);
        step();
        put(16'h0020);
        check_eq("hyst_shallow_we", {31'd0, write_enable}, 32'd0);
        step();
        put(16'hFC00);
        step();
        put(16'hFFF0);
        step();
        put(16'h0010);
        step();
        put(16'h4C00);
        check_eq("hyst_deep_we", {31'd0, write_enable}, 32'd1);
        check_eq("hyst_deep_addr", {23'd0, write_address}, 32'h100);
        step();
        reset_dut();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
